// File: rtl/forwarding_unit.sv
// EX-stage operand bypass select generation for the pipelined CPU, with
// registered select copies and saturating forwarding-event counters.
module forwarding_unit #(
    parameter int unsigned REG_AW     = 3,
    parameter int unsigned CNT_W      = 16,
    parameter bit          R0_IS_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] EX_rs,
    input  logic [REG_AW-1:0] EX_rt,
    input  logic [REG_AW-1:0] MEM_rd,
    input  logic [REG_AW-1:0] WB_rd,
    input  logic              MEM_regwrite,
    input  logic              WB_regwrite,
    input  logic              cnt_clr,
    output logic [1:0]        mux_in1,
    output logic [1:0]        mux_in2,
    output logic [1:0]        mux_in1_q,
    output logic [1:0]        mux_in2_q,
    output logic              fwd_any,
    output logic [CNT_W-1:0]  mem_fwd_cnt,
    output logic [CNT_W-1:0]  wb_fwd_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    logic mem_valid;
    logic wb_valid;
    logic mem_hit;
    logic wb_hit;

    // A stage is a forwarding source only if it writes a real (non-hardwired) register
    assign mem_valid = MEM_regwrite && !(R0_IS_ZERO && (MEM_rd == '0));
    assign wb_valid  = WB_regwrite  && !(R0_IS_ZERO && (WB_rd  == '0));

    // MEM holds the newer value, so it wins over WB
    always_comb begin
        mux_in1 = SEL_RF;
        if (mem_valid && (MEM_rd == EX_rs)) begin
            mux_in1 = SEL_MEM;
        end else if (wb_valid && (WB_rd == EX_rs)) begin
            mux_in1 = SEL_WB;
        end
    end

    always_comb begin
        mux_in2 = SEL_RF;
        if (mem_valid && (MEM_rd == EX_rt)) begin
            mux_in2 = SEL_MEM;
        end else if (wb_valid && (WB_rd == EX_rt)) begin
            mux_in2 = SEL_WB;
        end
    end

    assign fwd_any = (mux_in1 != SEL_RF) || (mux_in2 != SEL_RF);
    assign mem_hit = (mux_in1 == SEL_MEM) || (mux_in2 == SEL_MEM);
    assign wb_hit  = (mux_in1 == SEL_WB)  || (mux_in2 == SEL_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_in1_q <= SEL_RF;
            mux_in2_q <= SEL_RF;
        end else begin
            mux_in1_q <= mux_in1;
            mux_in2_q <= mux_in2;
        end
    end

    // Saturating event counters; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_fwd_cnt <= '0;
            wb_fwd_cnt  <= '0;
        end else if (cnt_clr) begin
            mem_fwd_cnt <= '0;
            wb_fwd_cnt  <= '0;
        end else begin
            if (mem_hit && (mem_fwd_cnt != '1)) begin
                mem_fwd_cnt <= mem_fwd_cnt + CNT_W'(1);
            end
            if (wb_hit && (wb_fwd_cnt != '1)) begin
                wb_fwd_cnt <= wb_fwd_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed vector table, hand sequences for
// counter/reset corners, and randomized stimulus against a reference model.
module tb_forwarding_unit;

    localparam int unsigned AW    = 3;
    localparam int unsigned CW    = 16;
    localparam int unsigned CW_Z  = 4;
    localparam int          MAX_M = (1 << CW) - 1;
    localparam int          MAX_Z = (1 << CW_Z) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ex_rs = '0, ex_rt = '0, mem_rd = '0, wb_rd = '0;
    logic          mem_rw = 1'b0, wb_rw = 1'b0, cnt_clr = 1'b0;

    logic [1:0]    m1, m2, m1q, m2q;
    logic          any;
    logic [CW-1:0] mcnt, wcnt;
    logic [1:0]    z1, z2, z1q, z2q;
    logic          zany;
    logic [CW_Z-1:0] zmcnt, zwcnt;

    int n_pass = 0;
    int n_total = 0;

    forwarding_unit dut (
        .clk(clk), .rst_n(rst_n), .EX_rs(ex_rs), .EX_rt(ex_rt),
        .MEM_rd(mem_rd), .WB_rd(wb_rd), .MEM_regwrite(mem_rw), .WB_regwrite(wb_rw),
        .cnt_clr(cnt_clr), .mux_in1(m1), .mux_in2(m2), .mux_in1_q(m1q), .mux_in2_q(m2q),
        .fwd_any(any), .mem_fwd_cnt(mcnt), .wb_fwd_cnt(wcnt)
    );

    forwarding_unit #(.REG_AW(AW), .CNT_W(CW_Z), .R0_IS_ZERO(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .EX_rs(ex_rs), .EX_rt(ex_rt),
        .MEM_rd(mem_rd), .WB_rd(wb_rd), .MEM_regwrite(mem_rw), .WB_regwrite(wb_rw),
        .cnt_clr(cnt_clr), .mux_in1(z1), .mux_in2(z2), .mux_in1_q(z1q), .mux_in2_q(z2q),
        .fwd_any(zany), .mem_fwd_cnt(zmcnt), .wb_fwd_cnt(zwcnt)
    );

    always #5 clk = ~clk;

    // Reference: which stage supplies the newest value of register src
    function automatic int model_sel(int src, int mrd, bit mrw, int wrd, bit wrw, bit r0z);
        bit mem_ok;
        bit wb_ok;
        mem_ok = mrw && !(r0z && mrd == 0);
        wb_ok  = wrw && !(r0z && wrd == 0);
        if (mem_ok && mrd == src) return 1;
        if (wb_ok && wrd == src) return 2;
        return 0;
    endfunction

    int e1q = 0, e2q = 0, em = 0, ew = 0;
    int ez1q = 0, ez2q = 0, ezm = 0, ezw = 0;

    always @(posedge clk or negedge rst_n) begin
        int s1, s2, t1, t2;
        if (!rst_n) begin
            e1q <= 0; e2q <= 0; em <= 0; ew <= 0;
            ez1q <= 0; ez2q <= 0; ezm <= 0; ezw <= 0;
        end else begin
            s1 = model_sel(int'(ex_rs), int'(mem_rd), mem_rw, int'(wb_rd), wb_rw, 1'b0);
            s2 = model_sel(int'(ex_rt), int'(mem_rd), mem_rw, int'(wb_rd), wb_rw, 1'b0);
            t1 = model_sel(int'(ex_rs), int'(mem_rd), mem_rw, int'(wb_rd), wb_rw, 1'b1);
            t2 = model_sel(int'(ex_rt), int'(mem_rd), mem_rw, int'(wb_rd), wb_rw, 1'b1);
            e1q <= s1; e2q <= s2; ez1q <= t1; ez2q <= t2;
            if (cnt_clr) begin
                em <= 0; ew <= 0; ezm <= 0; ezw <= 0;
            end else begin
                em  <= (s1 == 1 || s2 == 1) ? ((em  < MAX_M) ? em  + 1 : em)  : em;
                ew  <= (s1 == 2 || s2 == 2) ? ((ew  < MAX_M) ? ew  + 1 : ew)  : ew;
                ezm <= (t1 == 1 || t2 == 1) ? ((ezm < MAX_Z) ? ezm + 1 : ezm) : ezm;
                ezw <= (t1 == 2 || t2 == 2) ? ((ezw < MAX_Z) ? ezw + 1 : ezw) : ezw;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        int s1, s2, t1, t2;
        s1 = model_sel(int'(ex_rs), int'(mem_rd), mem_rw, int'(wb_rd), wb_rw, 1'b0);
        s2 = model_sel(int'(ex_rt), int'(mem_rd), mem_rw, int'(wb_rd), wb_rw, 1'b0);
        t1 = model_sel(int'(ex_rs), int'(mem_rd), mem_rw, int'(wb_rd), wb_rw, 1'b1);
        t2 = model_sel(int'(ex_rt), int'(mem_rd), mem_rw, int'(wb_rd), wb_rw, 1'b1);
        check("mux_in1", 32'(m1), 32'(s1));
        check("mux_in2", 32'(m2), 32'(s2));
        check("fwd_any", 32'(any), 32'(s1 != 0 || s2 != 0));
        check("mux_in1_q", 32'(m1q), 32'(e1q));
        check("mux_in2_q", 32'(m2q), 32'(e2q));
        check("mem_fwd_cnt", 32'(mcnt), 32'(em));
        check("wb_fwd_cnt", 32'(wcnt), 32'(ew));
        check("z.mux_in1", 32'(z1), 32'(t1));
        check("z.mux_in2", 32'(z2), 32'(t2));
        check("z.fwd_any", 32'(zany), 32'(t1 != 0 || t2 != 0));
        check("z.mux_in1_q", 32'(z1q), 32'(ez1q));
        check("z.mux_in2_q", 32'(z2q), 32'(ez2q));
        check("z.mem_fwd_cnt", 32'(zmcnt), 32'(ezm));
        check("z.wb_fwd_cnt", 32'(zwcnt), 32'(ezw));
    endtask

    task automatic drive(input int rs, input int rt, input int mrd, input int wrd,
                         input bit mrw, input bit wrw);
        ex_rs = AW'(rs); ex_rt = AW'(rt); mem_rd = AW'(mrd); wb_rd = AW'(wrd);
        mem_rw = mrw; wb_rw = wrw;
    endtask

    typedef struct {
        int rs, rt, mrd, wrd;
        bit mrw, wrw;
        int e1, e2;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{1, 0, 1, 0, 1'b1, 1'b0, 1, 0};
        vecs[2]  = '{1, 2, 2, 0, 1'b1, 1'b0, 0, 1};
        vecs[3]  = '{3, 0, 0, 0, 1'b0, 1'b0, 0, 0};
        vecs[4]  = '{5, 0, 5, 5, 1'b1, 1'b1, 1, 0};
        vecs[5]  = '{5, 0, 5, 5, 1'b0, 1'b1, 2, 0};
        vecs[6]  = '{5, 5, 5, 5, 1'b1, 1'b1, 1, 1};
        vecs[7]  = '{5, 5, 5, 5, 1'b0, 1'b1, 2, 2};
        vecs[8]  = '{3, 3, 3, 3, 1'b0, 1'b0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 1'b1, 1'b0, 1, 1};
        vecs[10] = '{0, 4, 6, 0, 1'b0, 1'b1, 2, 0};
        vecs[11] = '{2, 6, 2, 6, 1'b1, 1'b1, 1, 2};
        vecs[12] = '{7, 7, 3, 7, 1'b1, 1'b1, 2, 2};
        vecs[13] = '{6, 6, 6, 1, 1'b0, 1'b1, 0, 0};

        // Reset state; selects are live during reset
        #2;
        check("rst mux_in1_q", 32'(m1q), 32'd0);
        check("rst mem_fwd_cnt", 32'(mcnt), 32'd0);
        check("rst mux_in1", 32'(m1), 32'd0);
        check("rst fwd_any", 32'(any), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rs, vecs[i].rt, vecs[i].mrd, vecs[i].wrd, vecs[i].mrw, vecs[i].wrw);
            #1;
            check($sformatf("vec%0d mux_in1", i), 32'(m1), 32'(vecs[i].e1));
            check($sformatf("vec%0d mux_in2", i), 32'(m2), 32'(vecs[i].e2));
            check($sformatf("vec%0d fwd_any", i), 32'(any),
                  32'(vecs[i].e1 != 0 || vecs[i].e2 != 0));
            check_all();
        end

        // First MEM forward lands in the registered copy and counter one edge later
        @(negedge clk);
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        drive(1, 0, 1, 0, 1'b1, 1'b0);
        #1;
        check("seq mem_fwd_cnt before", 32'(mcnt), 32'd0);
        check("seq mux_in1 zero-latency", 32'(m1), 32'd1);
        @(negedge clk);
        #1;
        check("seq mux_in1_q", 32'(m1q), 32'd1);
        check("seq mem_fwd_cnt", 32'(mcnt), 32'd1);
        check_all();

        // Hardwired r0 on the second instance ignores address-0 destinations
        @(negedge clk);
        drive(0, 0, 0, 0, 1'b1, 1'b1);
        #1;
        check("r0 default mux_in1", 32'(m1), 32'd1);
        check("r0 zero mux_in1", 32'(z1), 32'd0);
        check("r0 zero fwd_any", 32'(zany), 32'd0);
        check_all();

        // Saturation: hold a MEM forward past the counter range
        @(negedge clk);
        drive(1, 1, 1, 0, 1'b1, 1'b0);
        repeat ((1 << CW) + 3) @(negedge clk);
        #1;
        check("sat mem_fwd_cnt", 32'(mcnt), 32'(MAX_M));
        check("sat z.mem_fwd_cnt", 32'(zmcnt), 32'(MAX_Z));
        check_all();

        // Clear wins over a simultaneous increment
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        drive(0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        check("clr mem_fwd_cnt", 32'(mcnt), 32'd0);
        check_all();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            drive(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7)),
                  int'($urandom_range(7)), 1'($urandom), 1'($urandom));
            cnt_clr = ($urandom_range(99) == 0);
            #1;
            check_all();
        end
        cnt_clr = 1'b0;

        // Reset between edges takes effect immediately, then counting resumes
        @(negedge clk);
        drive(2, 2, 2, 0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("pre-rst mem_fwd_cnt nonzero", 32'(mcnt != '0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst mux_in1_q", 32'(m1q), 32'd0);
        check("midrst mux_in2_q", 32'(m2q), 32'd0);
        check("midrst mem_fwd_cnt", 32'(mcnt), 32'd0);
        check("midrst wb_fwd_cnt", 32'(wcnt), 32'd0);
        check("midrst mux_in1", 32'(m1), 32'd1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post-rst mem_fwd_cnt", 32'(mcnt), 32'd1);
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
Name:
forwarding_unit

Overview:
- Data-hazard forwarding control for the 19-bit pipelined CPU with an 8-entry register file.
- Compares the EX-stage source registers against the MEM-stage and WB-stage destination registers.
- Generates the select codes for the two ALU-operand bypass muxes in EX.
- Also provides registered copies of the selects and saturating forwarding-event counters for debug and performance visibility.

Parameters:
- REG_AW, 3, register-address width.
- CNT_W, 16, width of each forwarding-event counter.
- R0_IS_ZERO, 0, when 1, register address 0 is hardwired zero and is never forwarded.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- EX_rs  in  REG_AW  source register 1 of the instruction in EX.
- EX_rt  in  REG_AW  source register 2 of the instruction in EX.
- MEM_rd  in  REG_AW  destination register of the instruction in MEM.
- WB_rd  in  REG_AW  destination register of the instruction in WB.
- MEM_regwrite  in  1  MEM-stage instruction writes the register file.
- WB_regwrite  in  1  WB-stage instruction writes the register file.
- cnt_clr  in  1  synchronous clear of the counters.
- mux_in1  out  2  operand-1 bypass select (combinational).
- mux_in2  out  2  operand-2 bypass select (combinational).
- mux_in1_q  out  2  mux_in1 registered.
- mux_in2_q  out  2  mux_in2 registered.
- fwd_any  out  1  combinational; high when either select is nonzero.
- mem_fwd_cnt  out  CNT_W  cycles with at least one MEM-stage forward.
- wb_fwd_cnt  out  CNT_W  cycles with at least one WB-stage forward (and no MEM forward on that operand).

Behaviour:
- Select encoding:
  - 2'b00: register-file value, no forward.
  - 2'b01: forward the EX/MEM result.
  - 2'b10: forward the MEM/WB result.
  - 2'b11: never produced.
- mux_in1 (fully combinational, zero latency; changes on any input change without waiting for clk):
  - 01 if MEM_regwrite && MEM_rd==EX_rs.
  - else 10 if WB_regwrite && WB_rd==EX_rs.
  - else 00.
- mux_in2: identical logic, using EX_rt.
- Priority: when both MEM and WB match the same source, MEM wins (01), because it holds the newest value.
- Both operands may forward at the same time, from the same or different stages.
- If EX_rs==EX_rt, both selects are equal.
- With R0_IS_ZERO=1, a match whose destination address is 0 is ignored. With the default 0, address 0 forwards like any other register.
- Regwrite low suppresses a match regardless of address equality.
- X on inputs need not be resolved; no latches allowed.
- Registered outputs:
  - mux_in1_q and mux_in2_q capture mux_in1 and mux_in2 on each rising clk edge.
  - Reset value 2'b00.
- Counters:
  - On each rising edge, mem_fwd_cnt increments if either select==01.
  - On each rising edge, wb_fwd_cnt increments if either select==10.
  - Each counter increments by at most 1 per cycle.
  - Counters saturate at all-ones and never wrap.
  - cnt_clr has priority over increment and forces 0 on the next edge.
- Reset:
  - rst_n low asynchronously forces mux_in1_q, mux_in2_q, mem_fwd_cnt and wb_fwd_cnt to 0.
  - Combinational outputs are unaffected by reset.
  - Reset asserted mid-operation discards counts immediately.
  - After deassertion, counting resumes on the first rising edge.

Test Plan:
- All inputs 0, both regwrites 0 -> mux_in1=00, mux_in2=00, fwd_any=0.
- MEM_rd=001, MEM_regwrite=1, EX_rs=001, EX_rt=000 -> mux_in1=01, mux_in2=00. Next edge: mux_in1_q=01, mem_fwd_cnt=1.
- Same as above, then MEM_rd=010, EX_rt=010 (EX_rs=001) -> mux_in1=00, mux_in2=01.
- EX_rs=011, MEM_rd=000, MEM_regwrite=0, WB_regwrite=0 -> mux_in1=00, mux_in2=00 (disabled write suppresses the match).
- Priority and both operands:
  - MEM_rd=WB_rd=101, both regwrites=1, EX_rs=101 -> mux_in1=01.
  - Then MEM_regwrite=0 -> mux_in1=10.
  - EX_rs=EX_rt=101 -> both selects equal.
- Counters and reset:
  - Hold a MEM forward for 2^CNT_W+3 cycles -> mem_fwd_cnt stays at all-ones.
  - Pulse cnt_clr -> 0.
  - Assert rst_n=0 between edges -> all registered outputs 0 immediately.
